// File: rtl/lcd_reader.sv
// rtl/lcd_reader.sv - HD44780 4-bit read engine (BF/AC or data byte as two nibble reads)
//
// Reads either the busy flag plus address counter (rd_sel=0, RS=0) or one
// DDRAM/CGRAM byte (rd_sel=1, RS=1) as two E strobes, high nibble first.
// While bus_own=1 the top level muxes this block onto lcd_rs/lcd_rw/lcd_e and
// releases lcd_d so the display can drive it.
//
// Optional feature macro: LCD_RD_POLL_EN
//   defined   : poll_req starts a BF/AC loop that repeats until BF=0, then
//               pulses rd_valid once with the final read.
//   undefined : poll_req is ignored; only single reads via rd_req.
//
// Parameters (cycles of clk_50, each 1..31):
//   T_AS  - RS/RW setup before E rises
//   T_EH  - E high time per nibble
//   T_SMP - E-high cycle in which lcd_d_in is captured (1 <= T_SMP < T_EH)
//   T_EL  - E low time after each nibble
//
// Ports:
//   clk_50    in   system clock
//   rst       in   synchronous active-high reset
//   rd_req    in   start a read (sampled in IDLE only)
//   rd_sel    in   0 = BF/AC, 1 = data; latched with rd_req
//   poll_req  in   start a busy-poll loop (LCD_RD_POLL_EN only)
//   rd_busy   out  transaction in progress
//   rd_valid  out  one-cycle pulse, rd_data valid
//   rd_data   out  assembled byte {hi, lo}, held until next rd_valid
//   busy_flag out  BF from the last BF/AC read
//   addr      out  AC from the last BF/AC read
//   bus_own   out  reader owns the LCD pins
//   lcd_rs    out  register select
//   lcd_rw    out  1 = read
//   lcd_e     out  enable strobe
//   lcd_d_in  in   LCD data bus, input side

module lcd_reader #(
    parameter int unsigned T_AS  = 3,
    parameter int unsigned T_EH  = 12,
    parameter int unsigned T_SMP = 10,
    parameter int unsigned T_EL  = 13
) (
    input  logic       clk_50,
    input  logic       rst,
    input  logic       rd_req,
    input  logic       rd_sel,
    input  logic       poll_req,
    output logic       rd_busy,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy_flag,
    output logic [6:0] addr,
    output logic       bus_own,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    input  logic [3:0] lcd_d_in
);

    localparam logic [4:0] AS_N  = 5'(T_AS);
    localparam logic [4:0] EH_N  = 5'(T_EH);
    localparam logic [4:0] SMP_N = 5'(T_SMP);
    localparam logic [4:0] EL_N  = 5'(T_EL);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EH1,
        EL1,
        EH2,
        EL2,
        DONE
    } state_t;

    state_t     state;
    logic [4:0] cnt;        // 1-based cycle index within the current state
    logic       sel;        // latched rd_sel for the running transaction
    logic [3:0] hi;
    logic [3:0] lo;
    logic       poll_mode;  // running a busy-poll loop
    logic       loop_again; // DONE must restart SETUP instead of returning to IDLE

`ifndef LCD_RD_POLL_EN
    logic unused_poll_req;
    assign unused_poll_req = poll_req;
`endif

    always_ff @(posedge clk_50) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 5'd0;
            sel        <= 1'b0;
            hi         <= 4'h0;
            lo         <= 4'h0;
            poll_mode  <= 1'b0;
            loop_again <= 1'b0;
            rd_busy    <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= 8'h00;
            busy_flag  <= 1'b0;
            addr       <= 7'h00;
            bus_own    <= 1'b0;
            lcd_rs     <= 1'b0;
            lcd_rw     <= 1'b0;
            lcd_e      <= 1'b0;
        end else begin
            rd_valid <= 1'b0;

            case (state)
                IDLE: begin
                    lcd_e   <= 1'b0;
                    lcd_rw  <= 1'b0;
                    bus_own <= 1'b0;
                    rd_busy <= 1'b0;
                    // rd_req has priority over poll_req when both arrive together
                    if (rd_req) begin
                        state     <= SETUP;
                        cnt       <= 5'd1;
                        sel       <= rd_sel;
                        poll_mode <= 1'b0;
                        rd_busy   <= 1'b1;
                        bus_own   <= 1'b1;
                        lcd_rw    <= 1'b1;
                        lcd_rs    <= rd_sel;
                    end
`ifdef LCD_RD_POLL_EN
                    else if (poll_req) begin
                        state     <= SETUP;
                        cnt       <= 5'd1;
                        sel       <= 1'b0;
                        poll_mode <= 1'b1;
                        rd_busy   <= 1'b1;
                        bus_own   <= 1'b1;
                        lcd_rw    <= 1'b1;
                        lcd_rs    <= 1'b0;
                    end
`endif
                end

                SETUP: begin
                    if (cnt == AS_N) begin
                        state <= EH1;
                        cnt   <= 5'd1;
                        lcd_e <= 1'b1;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end

                EH1: begin
                    if (cnt == SMP_N) begin
                        hi <= lcd_d_in;
                    end
                    if (cnt == EH_N) begin
                        state <= EL1;
                        cnt   <= 5'd1;
                        lcd_e <= 1'b0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end

                EL1: begin
                    if (cnt == EL_N) begin
                        state <= EH2;
                        cnt   <= 5'd1;
                        lcd_e <= 1'b1;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end

                EH2: begin
                    if (cnt == SMP_N) begin
                        lo <= lcd_d_in;
                    end
                    if (cnt == EH_N) begin
                        state <= EL2;
                        cnt   <= 5'd1;
                        lcd_e <= 1'b0;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end

                EL2: begin
                    if (cnt == EL_N) begin
                        state <= DONE;
                        cnt   <= 5'd1;
                        if (poll_mode && hi[3]) begin
                            // Display still busy: keep the pins and rd_busy,
                            // suppress rd_valid, and go around again.
                            loop_again <= 1'b1;
                            busy_flag  <= hi[3];
                            addr       <= {hi[2:0], lo};
                        end else begin
                            loop_again <= 1'b0;
                            rd_valid   <= 1'b1;
                            rd_data    <= {hi, lo};
                            if (!sel) begin
                                busy_flag <= hi[3];
                                addr      <= {hi[2:0], lo};
                            end
                            rd_busy <= 1'b0;
                            bus_own <= 1'b0;
                            lcd_rw  <= 1'b0;
                            lcd_rs  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end

                DONE: begin
                    if (loop_again) begin
                        state      <= SETUP;
                        cnt        <= 5'd1;
                        loop_again <= 1'b0;
                    end else begin
                        state     <= IDLE;
                        cnt       <= 5'd0;
                        poll_mode <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    cnt   <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: doc/lcd_reader.md
# lcd_reader

HD44780-compatible 4-bit read engine that reads from the character LCD. It fetches either the busy flag plus address counter (RS=0) or one DDRAM/CGRAM data byte (RS=1) as two nibble reads, high nibble first. It sits beside the LCD write/init path and drives the same lcd_rs, lcd_rw and lcd_e pins through the top-level mux. While it owns the bus it asks the top level to tristate lcd_d.

## Interface

Parameters:
- T_AS, default 3: cycles RS/RW are stable before E rises (at least 40 ns at 50 MHz).
- T_EH, default 12: E high cycles per nibble (at least 230 ns).
- T_SMP, default 10: E-high cycle in which lcd_d_in is captured (at least 160 ns after E rises). Must satisfy 1 ≤ T_SMP < T_EH.
- T_EL, default 13: E low cycles after each nibble (E cycle at least 500 ns).
- All timing parameters are in the range 1..31, using a 5-bit counter.

Ports:
- clk_50, in, 1: system clock, 50 MHz.
- rst, in, 1: reset. Synchronous, active-high.
- rd_req, in, 1: start a read. Sampled only in IDLE.
- rd_sel, in, 1: 0 reads BF/AC, 1 reads data. Latched with rd_req.
- poll_req, in, 1: start a busy-poll. Functional only with LCD_RD_POLL_EN.
- rd_busy, out, 1: transaction in progress.
- rd_valid, out, 1: one-cycle pulse, result is valid.
- rd_data, out, 8: assembled byte {hi, lo}. Held until the next rd_valid.
- busy_flag, out, 1: rd_data[7], updated only on BF/AC reads.
- addr, out, 7: rd_data[6:0], updated only on BF/AC reads.
- bus_own, out, 1: reader owns the LCD pins. The top level selects the reader outputs and releases lcd_d.
- lcd_rs, out, 1: register select.
- lcd_rw, out, 1: 1 means read.
- lcd_e, out, 1: enable strobe.
- lcd_d_in, in, 4: LCD data bus, input side.

## Operation

States are IDLE, SETUP, EH1, EL1, EH2, EL2, DONE.

- **IDLE**
  - lcd_e=0, lcd_rw=0, bus_own=0, rd_busy=0.
  - When rd_req=1: latch rd_sel, go to SETUP.
- **SETUP** (T_AS cycles): bus_own=1, lcd_rw=1, lcd_rs=rd_sel, lcd_e=0.
- **EH1** (T_EH cycles)
  - lcd_e=1.
  - In E-high cycle T_SMP, capture lcd_d_in into hi.
- **EL1** (T_EL cycles): lcd_e=0.
- **EH2 / EL2**: same as EH1/EL1, capturing lo.
- **DONE** (1 cycle)
  - rd_valid=1, rd_data={hi,lo}.
  - If the read was BF/AC, update busy_flag and addr.
  - lcd_rw=0, bus_own=0, rd_busy=0, then return to IDLE.

Rules:
- lcd_rs and lcd_rw are constant from SETUP through EL2.
- No E edge occurs while lcd_rw changes.
- rd_req or poll_req outside IDLE is ignored, not queued.
- rd_req and poll_req in the same cycle: rd_req wins.
- Reset mid-transaction, effective on the next edge:
  - all outputs take their reset values;
  - state goes to IDLE;
  - no rd_valid is emitted;
  - partial nibbles are discarded.

Reset values:
- lcd_e=0, lcd_rw=0, lcd_rs=0, bus_own=0.
- rd_busy=0, rd_valid=0.
- rd_data=8'h00, busy_flag=0, addr=7'h00.

## Timing

Cycle numbering, with defaults; rd_req is sampled at edge 0:
- Cycles 1–3: SETUP.
- Cycles 4–15: lcd_e=1. hi is captured at cycle 13.
- Cycles 16–28: EL1.
- Cycles 29–40: lcd_e=1. lo is captured at cycle 38.
- Cycles 41–53: EL2.
- Cycle 54: rd_valid=1.

General form:
- rd_busy=1 on cycles 1..(T_AS+2·(T_EH+T_EL)).
- Read latency = T_AS + 2·(T_EH+T_EL) + 1 = 54 cycles.
- Back-to-back reads: a new rd_req is accepted in the cycle after DONE, giving a minimum spacing of 55 cycles.
- All outputs are registered. No combinational path runs from inputs to LCD pins.

## Configuration

- **LCD_RD_POLL_EN defined**
  - poll_req starts a BF/AC read loop.
  - After each DONE with busy_flag=1, the block re-enters SETUP directly.
  - rd_valid is not pulsed between iterations.
  - rd_busy stays 1 throughout the loop.
  - When BF=0, the block pulses rd_valid once, with rd_data holding the final read.
  - rst aborts the loop.
- **LCD_RD_POLL_EN undefined**
  - poll_req is ignored.
  - Only single reads via rd_req are available.

## Test plan

- Reset, then idle for 10 cycles: all outputs hold their reset values, lcd_e never toggles.
- rd_req with rd_sel=0, LCD model returns 0x8 then 0x5:
  - rd_valid pulses at cycle 54;
  - rd_data=8'h85, busy_flag=1, addr=7'h05;
  - lcd_e high at cycles 4–15 and 29–40.
- rd_req with rd_sel=1, model returns 0x4 then 0x1:
  - rd_data=8'h41;
  - busy_flag and addr keep their previous values;
  - lcd_rs=1 on cycles 1–53.
- rd_req pulsed again at cycle 20: ignored. Exactly one rd_valid occurs, at cycle 54. A second rd_req at cycle 55 is accepted.
- rst asserted at cycle 30: from cycle 31 lcd_e=0, lcd_rw=0, bus_own=0, no rd_valid. A fresh read then completes normally.
- LCD_RD_POLL_EN defined, model returns BF=1 for 2 reads and then 0x0/0x7:
  - a single rd_valid pulses at cycle 3·54 = 162;
  - rd_data=8'h07;
  - rd_busy is continuous until then.
